// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the pipelined ALU.
//   op_e    - 4-bit opcode encoding (13..15 are unassigned and reported illegal)
//   state_e - top-level sequencing states
//   flags_t - status flags registered alongside the result
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL1 = 4'd6,
    OP_SHR1 = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_CMP  = 4'd11,
    OP_MUL  = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic neg;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_pipe_mul.sv
// alu_pipe_mul: iterative unsigned shift-add multiplier, one partial product
// per cycle, WIDTH cycles per operation.
//   clk, rst   - clock, synchronous active-high reset (abandons any operation)
//   start_i    - load operands and begin (ignored bookkeeping-wise if busy)
//   a_i, b_i   - operands, sampled on start_i
//   busy_o     - iteration in progress
//   done_o     - high in the cycle that performs the final iteration
//   product_o  - 2*WIDTH-bit accumulator; final once busy_o drops
module alu_pipe_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      a_sh_d = {{WIDTH{1'b0}}, a_i};
      b_sh_d = b_i;
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (b_sh_q[0]) begin
        acc_d = acc_q + a_sh_q;
      end
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == LAST);
  assign product_o = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready on both sides.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid, in_ready   - request handshake; a, b, op sampled on transfer
//   a, b, op             - operands and opcode; shift amount is b[SHW-1:0]
//   out_valid, out_ready - result handshake; output held while stalled
//   result               - WIDTH-bit result
//   zero, carry, ovf,    - status flags registered with the result
//   neg, illegal
// Single-cycle ops return one cycle after acceptance; MUL returns WIDTH+1
// cycles after acceptance via the iterative multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             neg,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   mul_res;
  flags_t             mul_fl;

  logic [WIDTH-1:0] alu_res;
  flags_t           alu_fl;

  // Single-cycle datapath. Everything is formed one bit wider than the
  // operands: the extra bit is the carry/borrow for add/sub, and for shifts
  // it catches the last bit shifted out (zero when the amount is zero).
  logic [SHW-1:0] sh;
  logic [WIDTH:0] sum_w, diff_w, shl_w, shr_w, sra_w;

  always_comb begin
    sh     = b[SHW-1:0];
    sum_w  = {1'b0, a} + {1'b0, b};
    diff_w = {1'b0, a} - {1'b0, b};
    shl_w  = {1'b0, a} << sh;
    shr_w  = {a, 1'b0} >> sh;
    sra_w  = $unsigned($signed({a, 1'b0}) >>> sh);

    alu_res = '0;
    alu_fl  = '0;
    case (op_e'(op))
      OP_ADD: begin
        alu_res      = sum_w[WIDTH-1:0];
        alu_fl.carry = sum_w[WIDTH];
        alu_fl.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res      = (op_e'(op) == OP_CMP) ? a : diff_w[WIDTH-1:0];
        alu_fl.carry = diff_w[WIDTH];
        alu_fl.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_SHL1: begin
        alu_res      = {a[WIDTH-2:0], 1'b0};
        alu_fl.carry = a[WIDTH-1];
      end
      OP_SHR1: begin
        alu_res      = {1'b0, a[WIDTH-1:1]};
        alu_fl.carry = a[0];
      end
      OP_SLL: begin
        alu_res      = shl_w[WIDTH-1:0];
        alu_fl.carry = shl_w[WIDTH];
      end
      OP_SRL: begin
        alu_res      = shr_w[WIDTH:1];
        alu_fl.carry = shr_w[0];
      end
      OP_SRA: begin
        alu_res      = sra_w[WIDTH:1];
        alu_fl.carry = sra_w[0];
      end
      OP_MUL: alu_res = '0;
      default: alu_fl.illegal = 1'b1;
    endcase
    alu_fl.zero = (alu_res == '0);
    alu_fl.neg  = alu_res[WIDTH-1];
  end

  alu_pipe_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  always_comb begin
    mul_res        = mul_product[WIDTH-1:0];
    mul_fl         = '0;
    mul_fl.zero    = (mul_res == '0);
    mul_fl.ovf     = |mul_product[2*WIDTH-1:WIDTH];
    mul_fl.neg     = mul_res[WIDTH-1];
  end

  // A new request may enter while the held result is leaving in the same
  // cycle, which keeps single-cycle ops at one result per clock.
  assign in_ready = !rst && (state_q == IDLE) && !mul_busy &&
                    (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    mul_start   = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            result_d    = alu_res;
            flags_d     = alu_fl;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!out_valid_q || out_ready) begin
          result_d    = mul_res;
          flags_d     = mul_fl;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign carry     = flags_q.carry;
  assign ovf       = flags_q.ovf;
  assign neg       = flags_q.neg;
  assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH=8. Expected results are
// queued when a request is accepted and compared when the result transfers.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] result;
  logic         zero, carry, ovf, neg, illegal;
  logic [4:0]   obs_fl;

  typedef struct {
    logic [7:0] res;
    logic [4:0] fl;
    logic [3:0] op;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   pops = 0;

  alu_pipe #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .ovf      (ovf),
    .neg      (neg),
    .illegal  (illegal)
  );

  assign obs_fl = {zero, carry, ovf, neg, illegal};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: integer arithmetic, shifts done one bit at a time.
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int ua, ub, ssa, ssb, s, t, r, sh;
    bit c, v, ill;
    ua = int'(x);
    ub = int'(y);
    ssa = (ua >= 128) ? ua - 256 : ua;
    ssb = (ub >= 128) ? ub - 256 : ub;
    c = 0; v = 0; ill = 0; r = 0;
    case (o)
      4'd0: begin
        s = ua + ub; r = s % 256; c = (s > 255);
        t = ssa + ssb; v = (t > 127) || (t < -128);
      end
      4'd1, 4'd11: begin
        s = ua - ub; r = (s + 256) % 256; c = (ua < ub);
        t = ssa - ssb; v = (t > 127) || (t < -128);
        if (o == 4'd11) r = ua;
      end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = 255 - ua;
      4'd6, 4'd8: begin
        sh = (o == 4'd6) ? 1 : (ub % 8);
        r = ua;
        for (int i = 0; i < sh; i++) begin
          c = (r >= 128);
          r = (r * 2) % 256;
        end
      end
      4'd7, 4'd9, 4'd10: begin
        sh = (o == 4'd7) ? 1 : (ub % 8);
        r = ua;
        for (int i = 0; i < sh; i++) begin
          c = (r % 2) == 1;
          r = r / 2 + ((o == 4'd10 && ua >= 128) ? 128 : 0);
        end
      end
      4'd12: begin
        s = ua * ub; r = s % 256; v = (s > 255);
      end
      default: ill = 1;
    endcase
    e.res = r[7:0];
    e.fl  = {r == 0, c, v, r >= 128, ill};
    e.op  = o;
    return e;
  endfunction

  task automatic push_exp(input logic [3:0] o, input logic [7:0] er, input logic [4:0] ef);
    exp_t e;
    e.res = er;
    e.fl  = ef;
    e.op  = o;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       input bit use_exp, input logic [7:0] er, input logic [4:0] ef,
                       output int waits);
    bit acc;
    acc = 0;
    waits = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      else waits++;
    end
    if (!acc) check_val("accept_timeout", 0, 1);
    else if (use_exp) push_exp(o, er, ef);
    else sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic mul_check(input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] er, input logic [4:0] ef);
    int w, lat, low;
    issue(4'd12, x, y, 1, er, ef, w);
    lat = 0;
    low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (!in_ready) low++;
      lat++;
    end
    check_val("mul_latency", lat, 9);
    check_val("mul_ready_low", low, 9);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pops++;
      if (sb.size() == 0) begin
        check_val("spurious_out", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val($sformatf("result_op%0d", mon_e.op), result, mon_e.res);
        check_val($sformatf("flags_op%0d", mon_e.op), obs_fl, mon_e.fl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, p0, nv;
    logic [3:0] o;

    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_result", result, 0);
    check_val("rst_flags", obs_fl, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_in_ready", in_ready, 1);
    check_val("idle_no_out", out_valid, 0);
    @(posedge clk); #1;

    // Directed cases: flags are {zero,carry,ovf,neg,illegal}
    issue(4'd0,  8'd10,   8'd5,   1, 8'd15,   5'b00000, w);
    issue(4'd0,  8'd200,  8'd100, 1, 8'd44,   5'b01000, w);
    issue(4'd0,  8'd127,  8'd1,   1, 8'd128,  5'b00110, w);
    issue(4'd1,  8'd5,    8'd10,  1, 8'd251,  5'b01010, w);
    issue(4'd11, 8'd7,    8'd7,   1, 8'd7,    5'b00000, w);
    issue(4'd0,  8'd0,    8'd0,   1, 8'd0,    5'b10000, w);
    issue(4'd10, 8'h90,   8'd3,   1, 8'hF2,   5'b00010, w);
    issue(4'd8,  8'h81,   8'd1,   1, 8'h02,   5'b01000, w);
    issue(4'd14, 8'd33,   8'd44,  1, 8'd0,    5'b10001, w);
    mul_check(8'd12, 8'd11, 8'd132, 5'b00010);
    mul_check(8'd20, 8'd20, 8'd144, 5'b00110);

    // Backpressure: held result stays put while a new request waits.
    out_ready = 1'b0;
    issue(4'd0, 8'd50, 8'd60, 1, 8'd110, 5'b00000, w);
    op = 4'd1; a = 8'd9; b = 8'd3; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("bp_valid", out_valid, 1);
      check_val("bp_result", result, 110);
      check_val("bp_flags", obs_fl, 0);
      check_val("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("refill_ready", in_ready, 1);
    if (in_ready) push_exp(4'd1, 8'd6, 5'b00000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    // Back-to-back stream of single-cycle ops
    p0 = pops;
    for (int i = 0; i < 8; i++) begin
      o = 4'($urandom_range(0, 12));
      if (o == 4'd12) o = 4'd13;
      issue(o, 8'($urandom), 8'($urandom), 0, 8'd0, 5'd0, w);
      check_val("stream_stall", w, 0);
    end
    @(posedge clk); #1;
    check_val("stream_pops", pops - p0, 8);

    // Reset in the middle of a multiply
    issue(4'd12, 8'd12, 8'd11, 1, 8'd132, 5'b00010, w);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_val("rst_mid_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_valid", out_valid, 0);
    check_val("post_rst_ready", in_ready, 1);
    nv = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check_val("abandoned_mul", nv, 0);
    @(posedge clk); #1;
    issue(4'd0, 8'd3, 8'd4, 1, 8'd7, 5'b00000, w);

    for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
    @(posedge clk); #1;
    check_val("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
